matmul_apb_arbiter: RTL and testbench
=====================================

// Module: matmul_apb_arbiter
// PURPOSE
//  Shares the single APB slave port of the matmul accelerator between NREQ APB masters.
//  Round-robin arbitration per transaction. A start-write lock gives the starting master sole
//  access until the accelerator drops busy, so its result reads cannot be interleaved.
//  Sits between the requesters (CPU, DMA, ...) and the matmul APB port; one per accelerator.
// PARAMETERS
//  NREQ        2             number of requesting APB masters (2..8)
//  BUS_WIDTH   32            APB data width (pwdata/prdata)
//  ADDR_WIDTH  16            APB address width
//  CTRL_ADDR   'h0           address of matmul control register
//  START_BIT   0             bit index of start in control register
// PORTS
//  clk_i        in   1                     clock; one clock domain
//  rst_n_i      in   1                     asynchronous, active-low reset
//  req_psel_i   in   NREQ                  per-requester psel
//  req_penable_i in  NREQ                  per-requester penable
//  req_pwrite_i in   NREQ                  per-requester pwrite
//  req_pstrb_i  in   NREQ*BUS_WIDTH/8      per-requester pstrb, packed, requester k at slice k
//  req_pwdata_i in   NREQ*BUS_WIDTH        per-requester write data, packed
//  req_paddr_i  in   NREQ*ADDR_WIDTH       per-requester address, packed
//  req_pready_o out  NREQ                  per-requester pready
//  req_pslverr_o out NREQ                  per-requester pslverr
//  req_prdata_o out  BUS_WIDTH             shared read data; valid only with own pready
//  psel_o, penable_o, pwrite_o  out 1      to matmul
//  pstrb_o out BUS_WIDTH/8; pwdata_o out BUS_WIDTH; paddr_o out ADDR_WIDTH   to matmul
//  pready_i, pslverr_i in 1; prdata_i in BUS_WIDTH   from matmul
//  busy_i       in   1                     matmul busy_o
//  grant_o      out  $clog2(NREQ)          current or last owner, for debug/coverage
//  lock_o       out  1                     start-lock active
// BEHAVIOUR
//  Reset: psel_o=penable_o=pwrite_o=0; paddr_o/pwdata_o/pstrb_o=0; rr pointer=0.
//    grant_o=0; lock_o=0; FSM=IDLE. Reset mid-transfer aborts; requesters see no pready.
//  FSM IDLE->SETUP->ACCESS->IDLE. All slave-side outputs are registered.
//  IDLE: eligible = req_psel_i, masked to the lock owner when lock_o=1.
//    If any eligible: pick first eligible at or after rr pointer (wrap at NREQ).
//    Latch its addr/wdata/strb/write, drive psel_o=1, penable_o=0 -> SETUP.
//  SETUP: one cycle; penable_o<=1 -> ACCESS.
//  ACCESS: hold until pready_i.
//    req_pready_o[g] = pready_i (combinational, only in ACCESS, only owner g).
//    req_pslverr_o[g] = pslverr_i & pready_i; req_prdata_o = prdata_i.
//    On pready_i: psel_o<=0, penable_o<=0, rr pointer<=g+1 mod NREQ -> IDLE.
//  Min latency: requester access completes 3 cycles after its psel if slave has zero waits.
//    Non-owners simply see wait states (pready_o=0); their requests are held, never dropped.
//  Back-to-back: one IDLE cycle between slave transfers; fairness bounded by NREQ transfers.
//  Lock: set at completion of a write from g to CTRL_ADDR with pwdata[START_BIT]=1.
//    Requires the strb byte covering START_BIT to be set and pslverr_i=0.
//    Lock clears when busy_i is seen low in IDLE after having been high, or after 2 cycles.
//    The 2-cycle path covers a start that never raises busy.
//    Owner keeps rr priority while locked; pointer not advanced.
//  Requester dropping psel while granted is a protocol violation.
//    The slave transfer still completes and the response is discarded (no pready to anyone).
//  Simultaneous lock clear and new requests: clear takes effect first; arbitration then uses rr pointer.
// STRUCTURE
//  matmul_pkg additions: typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS} arb_state_e;
//    constants MATMUL_CTRL_ADDR, MATMUL_START_BIT, ARB_NREQ default.
//  Sub-module matmul_rr_picker: combinational NREQ-wide round-robin picker.
//    Inputs: req vector, pointer. Outputs: grant index, valid. Reusable by other arbiters.
//  Top holds FSM, latch registers, lock tracking and response demux.
// TESTING
//  1. Single req0 write addr 'h10 data 'hA5A5A5A5, slave 0 waits.
//     Expect: psel_o at +1 cycle, penable_o at +2, req_pready_o[0] at +3, pslverr=0.
//  2. req0 & req1 both assert same cycle, pointer=0.
//     Expect: req0 served first, req1 served next with one IDLE cycle between; grant_o 0 then 1.
//  3. Three rounds of continuous requests from all NREQ=2 masters.
//     Expect: grants alternate 0,1,0,1,0,1; no starvation.
//  4. req1 writes CTRL 'h1, busy_i high 20 cycles, req0 requests meanwhile.
//     Expect: lock_o=1, req0 stalled, req1 reads of 'h20 served.
//     req0 granted in the first arbitration after busy_i falls.
//  5. Slave inserts 4 wait states then pslverr_i=1 on req1 read.
//     Expect: only req_pslverr_o[1]=1 for one cycle; req_pready_o[0] stays 0.
//  6. Assert rst_n_i in ACCESS.
//     Expect: all outputs 0 asynchronously, lock_o=0; after release, pending req re-arbitrated from pointer 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul accelerator and its APB arbiter.
package matmul_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } arb_state_e;

  localparam int unsigned MATMUL_CTRL_ADDR = 0;
  localparam int unsigned MATMUL_START_BIT = 0;
  localparam int          ARB_NREQ         = 2;
  // Cycles a start lock survives when busy never rises.
  localparam int unsigned ARB_LOCK_HOLD    = 2;

endpackage

// File: rtl/matmul_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping at NREQ.
module matmul_rr_picker
  import matmul_pkg::*;
#(
  parameter  int NREQ = ARB_NREQ,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   grant_o,
  output logic            valid_o
);

  logic [IW:0] sum;

  // Walk offsets from far to near so the nearest requester wins last.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(o);
      if (sum >= (IW + 1)'(NREQ)) sum = sum - (IW + 1)'(NREQ);
      if (req_i[sum[IW-1:0]]) begin
        grant_o = sum[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_apb_arbiter.sv
// Round-robin sharing of the matmul APB slave port between NREQ masters, with a start-write
// lock that keeps the starting master exclusive until the accelerator finishes.
module matmul_apb_arbiter
  import matmul_pkg::*;
#(
  parameter  int          NREQ       = ARB_NREQ,
  parameter  int          BUS_WIDTH  = 32,
  parameter  int          ADDR_WIDTH = 16,
  parameter  int unsigned CTRL_ADDR  = MATMUL_CTRL_ADDR,
  parameter  int unsigned START_BIT  = MATMUL_START_BIT,
  localparam int          GW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int          SW         = BUS_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NREQ-1:0]            req_psel_i,
  input  logic [NREQ-1:0]            req_penable_i,
  input  logic [NREQ-1:0]            req_pwrite_i,
  input  logic [NREQ*SW-1:0]         req_pstrb_i,
  input  logic [NREQ*BUS_WIDTH-1:0]  req_pwdata_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_paddr_i,
  output logic [NREQ-1:0]            req_pready_o,
  output logic [NREQ-1:0]            req_pslverr_o,
  output logic [BUS_WIDTH-1:0]       req_prdata_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic [SW-1:0]              pstrb_o,
  output logic [BUS_WIDTH-1:0]       pwdata_o,
  output logic [ADDR_WIDTH-1:0]      paddr_o,
  input  logic                       pready_i,
  input  logic                       pslverr_i,
  input  logic [BUS_WIDTH-1:0]       prdata_i,
  input  logic                       busy_i,
  output logic [GW-1:0]              grant_o,
  output logic                       lock_o
);

  arb_state_e            state_q, state_d;
  logic [GW-1:0]         owner_q, owner_d, ptr_q, ptr_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic                  lock_q, lock_d, busy_seen_q, busy_seen_d, abort_q, abort_d;
  logic [1:0]            lock_cnt_q, lock_cnt_d;

  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [NREQ-1:0] owner_oh, elig;
  logic            owner_psel, lock_clr, start_hit;
  logic [GW:0]     nxt;
  logic            unused_penable;

  // The slave handshake is driven from our own registers; requester penable carries no extra info.
  assign unused_penable = ^req_penable_i;

  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < NREQ; k++) owner_oh[k] = (owner_q == GW'(k));
  end

  assign owner_psel = |(req_psel_i & owner_oh);
  // Clear on busy falling in IDLE, or on timeout when busy was never observed.
  assign lock_clr   = lock_q & ~busy_i &
                      (busy_seen_q ? (state_q == ARB_IDLE) : (lock_cnt_q == 2'd0));
  assign elig       = (lock_q & ~lock_clr) ? (req_psel_i & owner_oh) : req_psel_i;
  assign start_hit  = pwrite_q & (paddr_q == ADDR_WIDTH'(CTRL_ADDR)) & pwdata_q[START_BIT] &
                      pstrb_q[START_BIT/8] & ~pslverr_i;

  matmul_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    lock_d      = lock_q;
    busy_seen_d = busy_seen_q;
    lock_cnt_d  = lock_cnt_q;
    abort_d     = abort_q;
    nxt         = {1'b0, owner_q} + (GW + 1)'(1);
    if (nxt >= (GW + 1)'(NREQ)) nxt = '0;

    if (lock_clr) begin
      lock_d      = 1'b0;
      busy_seen_d = 1'b0;
    end else if (lock_q) begin
      if (busy_i) busy_seen_d = 1'b1;
      else if (!busy_seen_q && lock_cnt_q != 2'd0) lock_cnt_d = lock_cnt_q - 2'd1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d   = ARB_SETUP;
          owner_d   = pick_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          abort_d   = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == GW'(k)) begin
              pwrite_d = req_pwrite_i[k];
              paddr_d  = req_paddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
              pwdata_d = req_pwdata_i[k*BUS_WIDTH +: BUS_WIDTH];
              pstrb_d  = req_pstrb_i[k*SW +: SW];
            end
          end
        end
      end
      ARB_SETUP: begin
        penable_d = 1'b1;
        state_d   = ARB_ACCESS;
        if (!owner_psel) abort_d = 1'b1;
      end
      ARB_ACCESS: begin
        if (!owner_psel) abort_d = 1'b1;
        if (pready_i) begin
          state_d   = ARB_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (start_hit) begin
            lock_d      = 1'b1;
            busy_seen_d = 1'b0;
            lock_cnt_d  = 2'(ARB_LOCK_HOLD);
            ptr_d       = owner_q;
          end else if (lock_q && !lock_clr) begin
            ptr_d = owner_q;
          end else begin
            ptr_d = nxt[GW-1:0];
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      lock_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      lock_cnt_q  <= 2'd0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      lock_q      <= lock_d;
      busy_seen_q <= busy_seen_d;
      lock_cnt_q  <= lock_cnt_d;
      abort_q     <= abort_d;
    end
  end

  // A requester that dropped psel mid-transfer gets no response.
  always_comb begin
    req_pready_o  = '0;
    req_pslverr_o = '0;
    if (state_q == ARB_ACCESS && !abort_q && pready_i) begin
      req_pready_o  = owner_oh & req_psel_i;
      req_pslverr_o = owner_oh & req_psel_i & {NREQ{pslverr_i}};
    end
  end

  assign req_prdata_o = prdata_i;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;
  assign grant_o      = owner_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_matmul_apb_arbiter.sv
// Scoreboard bench for matmul_apb_arbiter: per-master expected-response queues, a memory-backed
// slave model, directed arbitration/lock/reset scenarios and a randomized two-master phase.
module tb_matmul_apb_arbiter;
  import matmul_pkg::*;

  localparam int NREQ = 2, BW = 32, AW = 16, SW = BW / 8, GW = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_psel = '0, req_penable = '0, req_pwrite = '0;
  logic [NREQ*SW-1:0] req_pstrb = '0;
  logic [NREQ*BW-1:0] req_pwdata = '0;
  logic [NREQ*AW-1:0] req_paddr = '0;
  logic [NREQ-1:0]    req_pready_o, req_pslverr_o;
  logic [BW-1:0]      req_prdata_o;
  logic               psel_o, penable_o, pwrite_o;
  logic [SW-1:0]      pstrb_o;
  logic [BW-1:0]      pwdata_o;
  logic [AW-1:0]      paddr_o;
  logic               pready_i = 1'b0, pslverr_i = 1'b0, busy_i = 1'b0;
  logic [BW-1:0]      prdata_i = '0;
  logic [GW-1:0]      grant_o;
  logic               lock_o;

  matmul_apb_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_pstrb_i(req_pstrb), .req_pwdata_i(req_pwdata), .req_paddr_i(req_paddr),
    .req_pready_o(req_pready_o), .req_pslverr_o(req_pslverr_o), .req_prdata_o(req_prdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pstrb_o(pstrb_o), .pwdata_o(pwdata_o), .paddr_o(paddr_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
    .busy_i(busy_i), .grant_o(grant_o), .lock_o(lock_o)
  );

  typedef struct { logic wr; logic err; logic [31:0] data; } exp_t;
  exp_t        exp_q [NREQ][$];
  logic [31:0] model_mem [logic [15:0]];
  logic [31:0] slave_mem [logic [15:0]];
  logic [15:0] cur_addr [NREQ];
  logic        cur_wr   [NREQ];
  logic [31:0] cur_data [NREQ];
  int          done_cnt [NREQ];
  int          pslv_cnt [NREQ];
  int          rdy_cnt  [NREQ];
  int          gseq[$], ccyc[$];
  int          cyc = 0, force_waits = 0, wcnt = 0;
  int          checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_err(input logic [15:0] a);
    return a[15:12] == 4'hE;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One APB transfer from master k; call at posedge+#1, returns at posedge+#1 after completion.
  task automatic m_xfer(input int k, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   n;
    e.wr   = wr;
    e.err  = is_err(a);
    e.data = model_mem.exists(a) ? model_mem[a] : 32'h0;
    if (wr && !e.err) model_mem[a] = merge(e.data, d, s);
    exp_q[k].push_back(e);
    cur_addr[k] = a; cur_wr[k] = wr; cur_data[k] = d;
    req_paddr[k*AW +: AW]  = a;
    req_pwdata[k*BW +: BW] = d;
    req_pstrb[k*SW +: SW]  = s;
    req_pwrite[k]  = wr;
    req_psel[k]    = 1'b1;
    req_penable[k] = 1'b0;
    @(posedge clk); #1 req_penable[k] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_pready_o[k] && n < 400);
    chk($sformatf("pready_seen_req%0d", k), 32'(req_pready_o[k]), 32'd1);
    @(posedge clk); #1;
    req_psel[k]    = 1'b0;
    req_penable[k] = 1'b0;
    done_cnt[k]++;
  endtask

  // Slave model: memory, configurable wait states, error region at 'hE000.
  initial begin
    forever begin
      @(posedge clk); #1;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      if (psel_o && !penable_o) begin
        wcnt = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
      end else if (psel_o && penable_o) begin
        if (wcnt > 0) wcnt--;
        else begin
          pready_i  = 1'b1;
          pslverr_i = is_err(paddr_o);
          prdata_i  = pwrite_o ? $urandom :
                      (slave_mem.exists(paddr_o) ? slave_mem[paddr_o] : 32'h0);
          if (pwrite_o && !pslverr_i)
            slave_mem[paddr_o] = merge(slave_mem.exists(paddr_o) ? slave_mem[paddr_o] : 32'h0,
                                       pwdata_o, pstrb_o);
          gseq.push_back(int'(grant_o));
          ccyc.push_back(cyc);
          chk("slave_addr", 32'(paddr_o), 32'(cur_addr[grant_o]));
          chk("slave_write", 32'(pwrite_o), 32'(cur_wr[grant_o]));
          if (pwrite_o) chk("slave_wdata", pwdata_o, cur_data[grant_o]);
        end
      end
    end
  end

  // Monitor: pops the owner's expected response whenever a requester sees pready.
  always @(negedge clk) begin
    exp_t e;
    chk("pready_onehot", 32'($countones(req_pready_o) <= 1), 32'd1);
    chk("pslverr_only_with_pready", 32'(req_pslverr_o & ~req_pready_o), 32'd0);
    for (int k = 0; k < NREQ; k++) begin
      pslv_cnt[k] += int'(req_pslverr_o[k]);
      rdy_cnt[k]  += int'(req_pready_o[k]);
      if (req_pready_o[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected_req%0d: got pready expected none", k);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("pslverr_req%0d", k), 32'(req_pslverr_o[k]), 32'(e.err));
          if (!e.wr && !e.err) chk($sformatf("prdata_req%0d", k), req_prdata_o, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    gseq.delete();
    ccyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bstart, bf, d0, n;
    do_reset();
    @(negedge clk);
    chk("rst_psel", 32'(psel_o), 0);     chk("rst_penable", 32'(penable_o), 0);
    chk("rst_pwrite", 32'(pwrite_o), 0); chk("rst_paddr", 32'(paddr_o), 0);
    chk("rst_pwdata", pwdata_o, 0);      chk("rst_pstrb", 32'(pstrb_o), 0);
    chk("rst_grant", 32'(grant_o), 0);   chk("rst_lock", 32'(lock_o), 0);
    @(posedge clk); #1;

    // Single write, zero slave waits: psel_o +1, penable_o +2, pready +3.
    force_waits = 0;
    fork m_xfer(0, 1'b1, 16'h0010, 32'hA5A5A5A5, 4'hF); join_none
    @(negedge clk); chk("t1_psel_c0", 32'(psel_o), 0);
    @(negedge clk); chk("t1_psel_c1", 32'(psel_o), 1); chk("t1_pen_c1", 32'(penable_o), 0);
    chk("t1_rdy_c1", 32'(req_pready_o[0]), 0);
    @(negedge clk); chk("t1_pen_c2", 32'(penable_o), 1); chk("t1_rdy_c2", 32'(req_pready_o[0]), 1);
    chk("t1_paddr", 32'(paddr_o), 32'h10);
    wait fork;

    // Simultaneous requests from pointer 0.
    do_reset();
    fork
      m_xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF);
      m_xfer(1, 1'b1, 16'h0204, 32'h12345678, 4'hF);
    join
    chk("t2_count", gseq.size(), 2);
    chk("t2_first", gseq[0], 0); chk("t2_second", gseq[1], 1);
    chk("t2_gap", ccyc[1] - ccyc[0], 3);

    // Continuous traffic from both masters alternates.
    do_reset();
    fork
      repeat (3) m_xfer(0, 1'b1, 16'h0120, $urandom, 4'hF);
      repeat (3) m_xfer(1, 1'b0, 16'h0204, 32'h0, 4'hF);
    join
    chk("t3_count", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) chk($sformatf("t3_grant%0d", i), gseq[i], i % 2);

    // Start lock held while busy; req0 waits, req1 reads proceed.
    do_reset();
    m_xfer(1, 1'b1, 16'h0000, 32'h1, 4'hF);
    busy_i = 1'b1; bstart = cyc; d0 = done_cnt[0];
    @(negedge clk); chk("t4_lock_set", 32'(lock_o), 1);
    @(posedge clk); #1;
    fork m_xfer(0, 1'b0, 16'h0110, 32'h0, 4'hF); join_none
    m_xfer(1, 1'b0, 16'h0020, 32'h0, 4'hF);
    m_xfer(1, 1'b0, 16'h0020, 32'h0, 4'hF);
    chk("t4_req0_stalled", done_cnt[0], d0);
    chk("t4_lock_hold", 32'(lock_o), 1);
    while (cyc < bstart + 20) begin @(posedge clk); #1; end
    busy_i = 1'b0; bf = cyc;
    wait fork;
    chk("t4_last_grant", gseq[gseq.size()-1], 0);
    chk("t4_req0_latency", ccyc[ccyc.size()-1] - bf, 2);
    chk("t4_lock_clear", 32'(lock_o), 0);

    // Start without busy: lock expires on its own.
    m_xfer(1, 1'b1, 16'h0000, 32'h1, 4'hF);
    fork m_xfer(0, 1'b0, 16'h0110, 32'h0, 4'hF); join_none
    @(negedge clk); @(negedge clk); chk("t4b_lock_c2", 32'(lock_o), 1);
    @(negedge clk); @(negedge clk); chk("t4b_lock_c4", 32'(lock_o), 0);
    wait fork;
    // Start bit written without its byte strobe: no lock.
    m_xfer(1, 1'b1, 16'h0000, 32'h1, 4'hE);
    @(negedge clk); chk("t4c_no_lock", 32'(lock_o), 0);
    @(posedge clk); #1;

    // Wait states then slave error on req1 read.
    force_waits = 4;
    for (int k = 0; k < NREQ; k++) begin pslv_cnt[k] = 0; rdy_cnt[k] = 0; end
    n = cyc;
    m_xfer(1, 1'b0, 16'hE020, 32'h0, 4'hF);
    chk("t5_err1", pslv_cnt[1], 1); chk("t5_err0", pslv_cnt[0], 0);
    chk("t5_rdy0", rdy_cnt[0], 0);  chk("t5_waits", ccyc[ccyc.size()-1] - n, 6);
    force_waits = 0;

    // Reset during ACCESS, then re-arbitrate from pointer 0.
    do_reset();
    m_xfer(0, 1'b0, 16'h0118, 32'h0, 4'hF);
    force_waits = 10;
    fork m_xfer(1, 1'b0, 16'h0208, 32'h0, 4'hF); join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!(psel_o && penable_o) && n < 50);
    chk("t6_in_access", 32'(psel_o && penable_o), 1);
    chk("t6_owner1", 32'(grant_o), 1);
    @(posedge clk); #1;
    fork m_xfer(0, 1'b0, 16'h011C, 32'h0, 4'hF); join_none
    #2 rst_n = 1'b0;
    #1;
    chk("t6_psel", 32'(psel_o), 0); chk("t6_penable", 32'(penable_o), 0);
    chk("t6_grant", 32'(grant_o), 0); chk("t6_lock", 32'(lock_o), 0);
    chk("t6_paddr", 32'(paddr_o), 0); chk("t6_pready", 32'(req_pready_o), 0);
    gseq.delete(); ccyc.delete();
    force_waits = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    wait fork;
    chk("t6_first", gseq[0], 0); chk("t6_second", gseq[1], 1);

    // Randomized traffic with random waits, gaps, strobes and error addresses.
    force_waits = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        logic [15:0] a;
        a = 16'h0100 + {8'h0, 2'b0, 6'($urandom), 2'b0};
        if ($urandom_range(0, 4) == 0) a[15:12] = 4'hE;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        m_xfer(0, 1'($urandom), a, $urandom, 4'($urandom));
      end
      for (int j = 0; j < 40; j++) begin
        logic [15:0] b;
        b = 16'h0200 + {8'h0, 2'b0, 6'($urandom), 2'b0};
        if ($urandom_range(0, 4) == 0) b[15:12] = 4'hE;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        m_xfer(1, 1'($urandom), b, $urandom, 4'($urandom));
      end
    join
    @(negedge clk);
    chk("sb_drain0", exp_q[0].size(), 0);
    chk("sb_drain1", exp_q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
